dbg_display_select: RTL and testbench

Upstream stage of the four-digit seven-segment scanner. Selects which 16-bit CPU debug value feeds the scanner's q_a input. Three board push-buttons, debounced internally, drive it: mode cycles PC / instruction / register / cycle count; step walks the register index; hold freezes the shown value. It sits between the pipelined MIPS core's debug taps and the display driver.

---
 rtl/dbg_display_select_pkg.sv | 27 ++
 rtl/dbg_display_select_btn_debounce.sv | 64 ++++++
 rtl/dbg_display_select.sv | 126 ++++++++++++
 tb/tb_dbg_display_select.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_display_select_pkg.sv
// Shared definitions for the debug display selector: mode encodings,
// default debounce sizing and the 16-bit half-word selector.
package dbg_display_select_pkg;

    typedef enum logic [1:0] {
        MODE_PC    = 2'd0,
        MODE_INSTR = 2'd1,
        MODE_REG   = 2'd2,
        MODE_CYC   = 2'd3
    } mode_e;

    // 10 ms at 100 MHz
    localparam int unsigned DEB_CYCLES_DEFAULT = 32'd1000000;
    localparam int unsigned DEB_W_DEFAULT      = 32'd20;

    // Pick the upper or lower half of a 32-bit debug word for the 4-digit display.
    function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
        logic [15:0] res;
        if (hi) begin
            res = word[31:16];
        end else begin
            res = word[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dbg_display_select_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-clock pulse on each accepted press (release produces no pulse).
module btn_debounce
    import dbg_display_select_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 32'd1);
    localparam logic [DEB_W-1:0] CNT_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] CNT_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the accepted level; flip it on the last one.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = CNT_ZERO;
            // only the press direction is reported
            pulse_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchronizer, accepted level, counter and registered press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_display_select.sv
// Chooses which 16-bit slice of the core's debug taps feeds the seven-segment
// scanner. Buttons cycle the mode, walk the register index and freeze the display.
module dbg_display_select
    import dbg_display_select_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_mode,
    input  logic        btn_step,
    input  logic        btn_hold,
    input  logic        sw_hi,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [15:0] q_a,
    output logic [1:0]  mode,
    output logic        hold_led
);

    logic        mode_pulse_s;
    logic        step_pulse_s;
    logic        hold_pulse_s;
    logic [31:0] src_s;

    mode_e       mode_q;
    mode_e       mode_d;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    logic        frozen_q;
    logic        frozen_d;
    logic [31:0] cyc_q;
    logic [31:0] cyc_d;
    logic [15:0] q_a_q;
    logic [15:0] q_a_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_mode (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_mode),
        .pulse_o (mode_pulse_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_step (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_step),
        .pulse_o (step_pulse_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_hold),
        .pulse_o (hold_pulse_s)
    );

    // Next-state for mode, register index, freeze flag, cycle counter and the display word.
    always_comb begin
        mode_d   = mode_q;
        idx_d    = idx_q;
        frozen_d = frozen_q;
        cyc_d    = cyc_q + 32'd1;
        q_a_d    = q_a_q;
        src_s    = 32'd0;

        if (mode_pulse_s) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end else begin
            mode_d = mode_q;
        end

        // step is qualified by the mode in force before this clock's update
        if (step_pulse_s && (mode_q == MODE_REG)) begin
            idx_d = idx_q + 5'd1;
        end else begin
            idx_d = idx_q;
        end

        if (hold_pulse_s) begin
            frozen_d = ~frozen_q;
        end else begin
            frozen_d = frozen_q;
        end

        case (mode_q)
            MODE_PC:    src_s = pc;
            MODE_INSTR: src_s = instr;
            MODE_REG:   src_s = rf_data;
            MODE_CYC:   src_s = cyc_q;
            default:    src_s = pc;
        endcase

        if (frozen_q) begin
            q_a_d = q_a_q;
        end else begin
            q_a_d = half_sel(src_s, sw_hi);
        end
    end

    // State registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= MODE_PC;
            idx_q    <= 5'd0;
            frozen_q <= 1'b0;
            cyc_q    <= 32'd0;
            q_a_q    <= 16'd0;
        end else begin
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            frozen_q <= frozen_d;
            cyc_q    <= cyc_d;
            q_a_q    <= q_a_d;
        end
    end

    assign rf_addr  = idx_q;
    assign q_a      = q_a_q;
    assign mode     = mode_q;
    assign hold_led = frozen_q;

endmodule

// File: tb/tb_dbg_display_select.sv
// Self-checking bench for dbg_display_select with a short debounce window.
module tb_dbg_display_select;

    localparam int DEB = 4;

    logic        clk;
    logic        reset_n;
    logic [2:0]  braw;      // [0]=mode [1]=step [2]=hold
    logic        sw_hi;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rf_data;
    logic [4:0]  rf_addr;
    logic [15:0] q_a;
    logic [1:0]  mode;
    logic        hold_led;

    int checks = 0;
    int errors = 0;
    bit rnd_bus;

    // behavioural reference state
    int          m_mode;
    int          m_idx;
    bit          m_frozen;
    logic [31:0] m_cyc;
    logic [15:0] m_qa;
    bit          m_r1[3];
    bit          m_r2[3];
    bit          m_acc[3];
    int          m_run[3];
    bit          m_pulse[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file stand-in: each register holds its address times 0x11
    assign rf_data = {27'd0, rf_addr} * 32'h0000_0011;

    dbg_display_select #(.DEB_CYCLES(DEB), .DEB_W(20)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_mode (braw[0]),
        .btn_step (braw[1]),
        .btn_hold (braw[2]),
        .sw_hi    (sw_hi),
        .pc       (pc),
        .instr    (instr),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .q_a      (q_a),
        .mode     (mode),
        .hold_led (hold_led)
    );

    task automatic reset_model();
        m_mode = 0; m_idx = 0; m_frozen = 1'b0; m_cyc = 32'd0; m_qa = 16'd0;
        for (int b = 0; b < 3; b++) begin
            m_r1[b] = 1'b0; m_r2[b] = 1'b0; m_acc[b] = 1'b0; m_run[b] = 0; m_pulse[b] = 1'b0;
        end
    endtask

    // Advance one clock: update the model from the inputs present before the edge.
    task automatic tick();
        logic [31:0] src;
        int nm;
        int ni;
        bit s;
        case (m_mode)
            0:       src = pc;
            1:       src = instr;
            2:       src = m_idx * 32'h11;
            default: src = m_cyc;
        endcase
        if (!m_frozen) m_qa = sw_hi ? src[31:16] : src[15:0];
        nm = m_pulse[0] ? (m_mode + 1) % 4 : m_mode;
        ni = (m_pulse[1] && m_mode == 2) ? (m_idx + 1) % 32 : m_idx;
        if (m_pulse[2]) m_frozen = !m_frozen;
        m_mode = nm;
        m_idx  = ni;
        m_cyc  = m_cyc + 32'd1;
        // a button is accepted after DEB consecutive samples, seen two clocks late
        for (int b = 0; b < 3; b++) begin
            s = m_r2[b];
            m_r2[b] = m_r1[b];
            m_r1[b] = braw[b];
            m_pulse[b] = 1'b0;
            if (s != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_acc[b] = s;
                    m_run[b] = 0;
                    m_pulse[b] = s;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rnd_bus) begin
            pc    = $urandom;
            instr = $urandom;
        end
    endtask

    task automatic press(input int b, input int n);
        braw[b] = 1'b1;
        repeat (n) tick();
        braw[b] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        reset_n = 1'b0; braw = 3'b000; sw_hi = 1'b0; rnd_bus = 1'b1;
        pc = $urandom; instr = $urandom;
        #2;
        checks++;
        if ({q_a, mode, rf_addr, hold_led} !== 24'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 000000", {q_a, mode, rf_addr, hold_led});
        end
        reset_model();
        #10 reset_n = 1'b1;
        exp = pc[15:0];
        tick();
        checks++;
        if (q_a !== exp || mode !== 2'd0 || rf_addr !== 5'd0 || hold_led !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got q_a=%h mode=%0d addr=%0d hold=%0b want q_a=%h 0 0 0",
                     q_a, mode, rf_addr, hold_led, exp);
        end
    endtask

    task automatic test_mode_wrap();
        for (int i = 1; i <= 4; i++) begin
            press(0, 8);
            checks++;
            if (mode !== 2'(i % 4) || int'(mode) != m_mode) begin
                errors++;
                $display("FAIL mode_wrap: got mode=%0d want %0d", mode, i % 4);
            end
        end
        rnd_bus = 1'b0;
        pc = 32'h1234_ABCD;
        sw_hi = 1'b1;
        tick();
        checks++;
        if (q_a !== 16'h1234) begin
            errors++;
            $display("FAIL half_hi: got %h want 1234", q_a);
        end
        sw_hi = 1'b0;
        tick();
        checks++;
        if (q_a !== 16'hABCD) begin
            errors++;
            $display("FAIL half_lo: got %h want abcd", q_a);
        end
        rnd_bus = 1'b1;
    endtask

    task automatic test_bounce();
        int changes;
        logic [1:0] prev;
        changes = 0;
        prev = mode;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) braw[0] = ((i / 2) % 2 == 0);
            else braw[0] = 1'b1;
            if (i == 30) begin
                rnd_bus = 1'b0;
                instr = 32'h5A5A_C3E1;
            end
            if (i >= 30) braw[0] = 1'b0;
            tick();
            if (mode !== prev) changes++;
            prev = mode;
            checks++;
            if ({q_a, mode, rf_addr, hold_led} !== {m_qa, m_mode[1:0], m_idx[4:0], m_frozen}) begin
                errors++;
                $display("FAIL bounce_track: got q_a=%h mode=%0d addr=%0d hold=%0b want q_a=%h mode=%0d addr=%0d hold=%0b",
                         q_a, mode, rf_addr, hold_led, m_qa, m_mode, m_idx, m_frozen);
            end
        end
        checks++;
        if (changes != 1 || mode !== 2'd1 || q_a !== 16'hC3E1) begin
            errors++;
            $display("FAIL bounce_once: got changes=%0d mode=%0d q_a=%h want 1 1 c3e1", changes, mode, q_a);
        end
        rnd_bus = 1'b1;
        // short glitches never survive the debounce window
        for (int g = 0; g < 12; g++) begin
            braw[0] = 1'b1;
            repeat ($urandom_range(1, DEB - 1)) tick();
            braw[0] = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (8) tick();
        checks++;
        if (mode !== 2'd1 || m_mode != 1) begin
            errors++;
            $display("FAIL glitch_ignored: got mode=%0d want 1", mode);
        end
    endtask

    task automatic test_reg_walk();
        bit saw31;
        bit wrapped;
        int budget;
        saw31 = 1'b0; wrapped = 1'b0;
        press(0, 8);
        for (int i = 0; i < 32; i++) begin
            press(1, 8);
            if (rf_addr == 5'd31) saw31 = 1'b1;
            if (saw31 && rf_addr == 5'd0) wrapped = 1'b1;
            checks++;
            if ({q_a, mode, rf_addr, hold_led} !== {m_qa, m_mode[1:0], m_idx[4:0], m_frozen}) begin
                errors++;
                $display("FAIL reg_walk: got q_a=%h mode=%0d addr=%0d want q_a=%h mode=%0d addr=%0d",
                         q_a, mode, rf_addr, m_qa, m_mode, m_idx);
            end
        end
        sw_hi = 1'b0;
        braw[1] = 1'b1;
        budget = 0;
        while (rf_addr !== 5'd1 && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        checks++;
        if (rf_addr !== 5'd1 || !wrapped || q_a !== 16'h0011) begin
            errors++;
            $display("FAIL reg_wrap: got addr=%0d wrapped=%0b q_a=%h want 1 1 0011", rf_addr, wrapped, q_a);
        end
        braw[1] = 1'b0;
        repeat (8) tick();
        press(0, 8);
        press(0, 8);
        press(1, 8);
        checks++;
        if (rf_addr !== 5'd1 || mode !== 2'd0 || m_idx != 1) begin
            errors++;
            $display("FAIL step_wrong_mode: got addr=%0d mode=%0d want 1 0", rf_addr, mode);
        end
    endtask

    task automatic test_hold();
        logic [15:0] fv;
        int budget;
        press(0, 8); press(0, 8); press(0, 8);
        sw_hi = 1'b0;
        braw[2] = 1'b1;
        budget = 0;
        while (hold_led !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        fv = q_a;
        checks++;
        if (hold_led !== 1'b1 || mode !== 2'd3 || fv !== m_qa) begin
            errors++;
            $display("FAIL hold_on: got hold=%0b mode=%0d q_a=%h want 1 3 %h", hold_led, mode, fv, m_qa);
        end
        braw[2] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (q_a !== fv || q_a !== m_qa) begin
                errors++;
                $display("FAIL hold_frozen: got q_a=%h want %h", q_a, fv);
            end
        end
        press(0, 8);
        checks++;
        if (mode !== 2'd0 || q_a !== fv || hold_led !== 1'b1) begin
            errors++;
            $display("FAIL hold_mode: got mode=%0d q_a=%h hold=%0b want 0 %h 1", mode, q_a, hold_led, fv);
        end
        rnd_bus = 1'b0;
        pc = 32'hCAFE_F00D;
        braw[2] = 1'b1;
        budget = 0;
        while (hold_led !== 1'b0 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (hold_led !== 1'b0 || q_a !== fv) begin
            errors++;
            $display("FAIL hold_off: got hold=%0b q_a=%h want 0 %h", hold_led, q_a, fv);
        end
        tick();
        checks++;
        if (q_a !== 16'hF00D) begin
            errors++;
            $display("FAIL hold_reload: got q_a=%h want f00d", q_a);
        end
        braw[2] = 1'b0;
        repeat (8) tick();
        rnd_bus = 1'b1;
    endtask

    task automatic test_simultaneous();
        press(0, 8); press(0, 8);
        repeat (4) press(1, 8);
        checks++;
        if (mode !== 2'd2 || rf_addr !== 5'd5) begin
            errors++;
            $display("FAIL simul_setup: got mode=%0d addr=%0d want 2 5", mode, rf_addr);
        end
        braw = 3'b111;
        repeat (8) tick();
        braw = 3'b000;
        repeat (8) tick();
        checks++;
        if (mode !== 2'd3 || rf_addr !== 5'd6 || hold_led !== 1'b1 ||
            {q_a, mode, rf_addr, hold_led} !== {m_qa, m_mode[1:0], m_idx[4:0], m_frozen}) begin
            errors++;
            $display("FAIL simul_pulses: got mode=%0d addr=%0d hold=%0b q_a=%h want 3 6 1 %h",
                     mode, rf_addr, hold_led, q_a, m_qa);
        end
        press(2, 8);
    endtask

    task automatic test_reset_mid();
        int budget;
        braw = 3'b001;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({q_a, mode, rf_addr, hold_led} !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 000000", {q_a, mode, rf_addr, hold_led});
        end
        reset_model();
        #10 reset_n = 1'b1;
        budget = 0;
        while (budget < 12) begin
            tick();
            budget++;
            checks++;
            if ({q_a, mode, rf_addr, hold_led} !== {m_qa, m_mode[1:0], m_idx[4:0], m_frozen}) begin
                errors++;
                $display("FAIL reset_held_btn: got q_a=%h mode=%0d addr=%0d want q_a=%h mode=%0d addr=%0d",
                         q_a, mode, rf_addr, m_qa, m_mode, m_idx);
            end
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL reset_repress: got mode=%0d want 1", mode);
        end
        braw = 3'b000;
        repeat (8) tick();
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 400; seg++) begin
            braw  = 3'($urandom_range(0, 7));
            sw_hi = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) begin
                tick();
                checks++;
                if ({q_a, mode, rf_addr, hold_led} !== {m_qa, m_mode[1:0], m_idx[4:0], m_frozen}) begin
                    errors++;
                    $display("FAIL random: got q_a=%h mode=%0d addr=%0d hold=%0b want q_a=%h mode=%0d addr=%0d hold=%0b",
                             q_a, mode, rf_addr, hold_led, m_qa, m_mode, m_idx, m_frozen);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_wrap();
        test_bounce();
        test_reg_walk();
        test_hold();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
